// File: rtl/tsu_mq_pkg.sv
// Shared sizing helpers and entry field offsets for the multi-channel timestamp queue.
package tsu_mq_pkg;

   function automatic int calc_chw(input int nch);
      if (nch <= 1) begin
         return 1;
      end else begin
         return $clog2(nch);
      end
   endfunction

   function automatic int calc_aw(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int ts_lsb();
      return 0;
   endfunction

   function automatic int info_lsb(input int ts_w);
      return ts_w;
   endfunction

   function automatic int ch_lsb(input int ts_w, input int info_w);
      return ts_w + info_w;
   endfunction

endpackage

// File: rtl/tsu_sfifo.sv
// Single-clock show-ahead FIFO; head entry is presented combinationally, zero when empty.
module tsu_sfifo
   import tsu_mq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = calc_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      used,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_next;
   logic             push;
   logic             pop;

   // Write is accepted when not full, or when a pop frees a slot on the same edge.
   always_comb begin
      pop   = rd_en & (used != '0);
      push  = wr_en & (~full | pop);
      empty = (used == '0);
      case ({push, pop})
         2'b10:   count_next = used + (AW+1)'(1);
         2'b01:   count_next = used - (AW+1)'(1);
         default: count_next = used;
      endcase
      if (used != '0) begin
         rd_data = mem[rd_ptr];
      end else begin
         rd_data = '0;
      end
   end

   // Pointer and occupancy registers; pointers wrap naturally as DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
         full   <= 1'b0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
         full   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         used <= count_next;
         full <= (count_next == (AW+1)'(DEPTH));
      end
   end

   // Storage array; contents are don't-care while the matching slot is not occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/tsu_mq.sv
// Multi-channel timestamp queue: per-channel capture slots merged round-robin into a show-ahead FIFO.
module tsu_mq
   import tsu_mq_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int TS_W   = 30,
   parameter int INFO_W = 18,
   parameter int DEPTH  = 16,
   localparam int CHW = calc_chw(NCH),
   localparam int AW  = calc_aw(DEPTH),
   localparam int EW  = CHW + INFO_W + TS_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [TS_W-1:0]       rtc_time,
   input  logic [NCH-1:0]        ev_valid,
   input  logic [NCH*INFO_W-1:0] ev_info,
   input  logic                  q_clr,
   input  logic                  q_rd_en,
   output logic                  q_rd_valid,
   output logic [EW-1:0]         q_rd_data,
   output logic [AW:0]           q_rd_used,
   output logic                  q_full,
   output logic [15:0]           q_drop_cnt
);

   localparam int SW = INFO_W + TS_W;

   logic [NCH-1:0] slot_valid;
   logic [SW-1:0]  slot_data [NCH];
   logic [CHW-1:0] ptr;
   logic [CHW-1:0] grant;
   logic           grant_valid;
   logic           pop;
   logic           wr_ok;
   logic           wr_en;
   logic [NCH-1:0] drained;
   logic [NCH-1:0] load;
   logic [NCH-1:0] drop;
   logic [4:0]     ndrop;
   logic [16:0]    drop_sum;
   logic [15:0]    drop_next;
   logic           fifo_full;
   logic           fifo_empty;
   logic [EW-1:0]  wr_data;

   // Round-robin pick: scan offsets high to low so the nearest valid slot at/after ptr wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % NCH;
         if (slot_valid[CHW'(idx)]) begin
            grant       = CHW'(idx);
            grant_valid = 1'b1;
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

   // Slot load/drop decisions and saturating drop accumulation.
   always_comb begin
      pop     = q_rd_en & ~fifo_empty;
      wr_ok   = ~fifo_full | pop;
      wr_en   = grant_valid & wr_ok;
      wr_data = {grant, slot_data[grant]};
      ndrop   = '0;
      for (int i = 0; i < NCH; i++) begin
         drained[i] = wr_en & (grant == CHW'(i));
         load[i]    = ev_valid[i] & (~slot_valid[i] | drained[i]);
         drop[i]    = ev_valid[i] & slot_valid[i] & ~drained[i];
         ndrop      = ndrop + 5'(drop[i]);
      end
      drop_sum = {1'b0, q_drop_cnt} + 17'(ndrop);
      if (drop_sum[16]) begin
         drop_next = 16'hFFFF;
      end else begin
         drop_next = drop_sum[15:0];
      end
   end

   // Capture slots, arbiter pointer and drop counter; flush behaves like reset.
   always_ff @(posedge clk) begin
      if (!rst_n || q_clr) begin
         slot_valid <= '0;
         ptr        <= '0;
         q_drop_cnt <= 16'h0000;
         for (int i = 0; i < NCH; i++) begin
            slot_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (load[i]) begin
               slot_valid[i] <= 1'b1;
               slot_data[i]  <= {ev_info[i*INFO_W +: INFO_W], rtc_time};
            end else if (drained[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
         if (wr_en) begin
            if (grant == CHW'(NCH - 1)) begin
               ptr <= '0;
            end else begin
               ptr <= grant + CHW'(1);
            end
         end
         q_drop_cnt <= drop_next;
      end
   end

   tsu_sfifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (q_clr),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (q_rd_en),
      .rd_data (q_rd_data),
      .used    (q_rd_used),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign q_rd_valid = ~fifo_empty;
   assign q_full     = fifo_full;

endmodule

// File: tb/tb_tsu_mq.sv
// Scoreboard bench for tsu_mq: queue-based reference model, negedge monitor, directed and random stimulus.
module tb_tsu_mq;

   localparam int NCH    = 4;
   localparam int TS_W   = 30;
   localparam int INFO_W = 18;
   localparam int DEPTH  = 16;
   localparam int CHW    = 2;
   localparam int AW     = 4;
   localparam int EW     = CHW + INFO_W + TS_W;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [TS_W-1:0]       rtc_time;
   logic [NCH-1:0]        ev_valid;
   logic [NCH*INFO_W-1:0] ev_info;
   logic                  q_clr;
   logic                  q_rd_en;
   logic                  q_rd_valid;
   logic [EW-1:0]         q_rd_data;
   logic [AW:0]           q_rd_used;
   logic                  q_full;
   logic [15:0]           q_drop_cnt;

   always #5 clk = ~clk;

   tsu_mq #(.NCH(NCH), .TS_W(TS_W), .INFO_W(INFO_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rtc_time   (rtc_time),
      .ev_valid   (ev_valid),
      .ev_info    (ev_info),
      .q_clr      (q_clr),
      .q_rd_en    (q_rd_en),
      .q_rd_valid (q_rd_valid),
      .q_rd_data  (q_rd_data),
      .q_rd_used  (q_rd_used),
      .q_full     (q_full),
      .q_drop_cnt (q_drop_cnt)
   );

   // reference model state
   logic [EW-1:0]          exp_q [$];
   bit                     m_slot_v [NCH];
   logic [INFO_W+TS_W-1:0] m_slot_d [NCH];
   int                     m_ptr;
   int                     m_drop;
   int                     checks = 0;
   int                     errors = 0;
   bit                     mon_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit pop;
      bit can_wr;
      int g;
      if (!rst_n || q_clr) begin
         exp_q.delete();
         for (int i = 0; i < NCH; i++) m_slot_v[i] = 1'b0;
         m_ptr  = 0;
         m_drop = 0;
      end else begin
         pop    = q_rd_en && (exp_q.size() > 0);
         can_wr = (exp_q.size() < DEPTH) || pop;
         if (pop) void'(exp_q.pop_front());
         g = -1;
         for (int k = 0; k < NCH; k++) begin
            if (g < 0 && m_slot_v[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
         end
         if (g >= 0 && can_wr) begin
            exp_q.push_back({CHW'(g), m_slot_d[g]});
            m_slot_v[g] = 1'b0;
            m_ptr = (g + 1) % NCH;
         end
         for (int i = 0; i < NCH; i++) begin
            if (ev_valid[i]) begin
               if (!m_slot_v[i]) begin
                  m_slot_v[i] = 1'b1;
                  m_slot_d[i] = {ev_info[i*INFO_W +: INFO_W], rtc_time};
               end else if (m_drop < 65535) begin
                  m_drop++;
               end
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            chk("valid", 64'(q_rd_valid), 64'(exp_q.size() != 0));
            chk("used", 64'(q_rd_used), 64'(exp_q.size()));
            chk("full", 64'(q_full), 64'(exp_q.size() == DEPTH));
            chk("drop_cnt", 64'(q_drop_cnt), 64'(m_drop));
            if (q_rd_valid) begin
               if (exp_q.size() > 0) chk("head_data", 64'(q_rd_data), 64'(exp_q[0]));
               else chk("head_unexpected", 64'(q_rd_valid), 64'(0));
            end else begin
               chk("empty_data", 64'(q_rd_data), 64'(0));
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ev_valid = '0;
      q_rd_en  = 1'b0;
      q_clr    = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_info(input int ch, input logic [INFO_W-1:0] v);
      ev_info[ch*INFO_W +: INFO_W] = v;
   endtask

   logic [EW-1:0] e;
   logic [TS_W-1:0] base;

   initial begin
      rst_n = 1'b0; rtc_time = '0; ev_info = '0;
      idle_inputs();
      tick();
      tick();
      mon_on = 1'b1;
      chk("rst_valid", 64'(q_rd_valid), 64'(0));
      chk("rst_used", 64'(q_rd_used), 64'(0));
      chk("rst_drop", 64'(q_drop_cnt), 64'(0));
      rst_n = 1'b1;

      // single event with latency check
      ev_valid = 4'b0100; set_info(2, 18'h00155); rtc_time = 30'h1234567;
      tick();
      ev_valid = '0;
      chk("lat_c1_valid", 64'(q_rd_valid), 64'(0));
      tick();
      e = {2'd2, 18'h00155, 30'h1234567};
      chk("lat_c2_valid", 64'(q_rd_valid), 64'(1));
      chk("single_data", 64'(q_rd_data), 64'(e));
      chk("single_used", 64'(q_rd_used), 64'(1));
      q_rd_en = 1'b1;
      tick();
      q_rd_en = 1'b0;
      chk("single_pop_used", 64'(q_rd_used), 64'(0));

      // four simultaneous events, then ch3+ch0
      do_reset();
      rtc_time = 30'd100;
      for (int i = 0; i < NCH; i++) set_info(i, 18'(i + 1));
      ev_valid = 4'hF;
      tick();
      ev_valid = '0;
      for (int i = 0; i < 4; i++) tick();
      chk("rr4_used", 64'(q_rd_used), 64'(4));
      for (int i = 0; i < 4; i++) begin
         chk("rr4_order", 64'(q_rd_data[EW-1 -: CHW]), 64'(i));
         chk("rr4_ts", 64'(q_rd_data[TS_W-1:0]), 64'(100));
         q_rd_en = 1'b1;
         tick();
      end
      q_rd_en = 1'b0;
      ev_valid = 4'b1001;
      tick();
      ev_valid = '0;
      tick(); tick();
      chk("rr2_first", 64'(q_rd_data[EW-1 -: CHW]), 64'(0));
      q_rd_en = 1'b1;
      tick();
      q_rd_en = 1'b0;
      chk("rr2_second", 64'(q_rd_data[EW-1 -: CHW]), 64'(3));

      // back-to-back on ch1
      do_reset();
      base = 30'd5000;
      for (int i = 0; i < 8; i++) begin
         ev_valid = 4'b0010; rtc_time = base + 30'(i); set_info(1, 18'(i));
         tick();
      end
      ev_valid = '0;
      tick(); tick();
      chk("b2b_used", 64'(q_rd_used), 64'(8));
      chk("b2b_drop", 64'(q_drop_cnt), 64'(0));
      for (int i = 0; i < 8; i++) begin
         chk("b2b_ts", 64'(q_rd_data[TS_W-1:0]), 64'(base + 30'(i)));
         q_rd_en = 1'b1;
         tick();
      end
      q_rd_en = 1'b0;

      // full handling
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ev_valid = 4'(1 << (i % 4)); rtc_time = 30'(200 + i);
         tick();
      end
      ev_valid = '0;
      tick(); tick();
      chk("full_used", 64'(q_rd_used), 64'(16));
      chk("full_flag", 64'(q_full), 64'(1));
      ev_valid = 4'b0001; rtc_time = 30'd300;
      tick();
      ev_valid = '0;
      tick();
      chk("held_used", 64'(q_rd_used), 64'(16));
      ev_valid = 4'b0001; rtc_time = 30'd301;
      tick();
      ev_valid = '0;
      chk("drop_one", 64'(q_drop_cnt), 64'(1));
      q_rd_en = 1'b1;
      tick();
      q_rd_en = 1'b0;
      chk("pop_at_full_used", 64'(q_rd_used), 64'(16));
      ev_valid = 4'b0010; rtc_time = 30'd302;
      tick();
      ev_valid = '0;
      q_rd_en = 1'b1;
      tick();
      q_rd_en = 1'b0;
      chk("pop_wr_full_used", 64'(q_rd_used), 64'(16));
      ev_valid = 4'hF;
      for (int i = 0; i < 22000; i++) tick();
      ev_valid = '0;
      chk("drop_sat", 64'(q_drop_cnt), 64'(16'hFFFF));
      ev_valid = 4'hF;
      tick(); tick();
      ev_valid = '0;
      chk("drop_sat_hold", 64'(q_drop_cnt), 64'(16'hFFFF));

      // empty read
      do_reset();
      q_rd_en = 1'b1;
      tick(); tick(); tick();
      q_rd_en = 1'b0;
      chk("empty_rd_used", 64'(q_rd_used), 64'(0));
      chk("empty_rd_valid", 64'(q_rd_valid), 64'(0));

      // flush, then the same sequence using reset (with q_clr also asserted)
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         ev_valid = 4'hF; tick();
         ev_valid = 4'h0; tick();
         ev_valid = 4'hF; tick();
         ev_valid = 4'h0; tick();
         tick();
         ev_valid = 4'b0100; tick();
         chk("pre_flush_used", 64'(q_rd_used), 64'(5));
         ev_valid = 4'hF;
         q_clr = 1'b1;
         if (pass == 1) rst_n = 1'b0;
         tick();
         q_clr = 1'b0; rst_n = 1'b1; ev_valid = '0;
         chk("flush_used", 64'(q_rd_used), 64'(0));
         chk("flush_valid", 64'(q_rd_valid), 64'(0));
         chk("flush_drop", 64'(q_drop_cnt), 64'(0));
         tick(); tick();
         chk("flush_slots_gone", 64'(q_rd_used), 64'(0));
      end

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rtc_time = rtc_time + 30'd1;
         ev_info  = 72'({$urandom(), $urandom(), $urandom()});
         ev_valid = 4'($urandom() & $urandom());
         q_rd_en  = ($urandom_range(0, 9) < 5);
         q_clr    = ($urandom_range(0, 199) == 0);
         rst_n    = ($urandom_range(0, 499) != 0);
         tick();
      end
      idle_inputs();
      rst_n = 1'b1;
      tick();

      mon_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
